// File: rtl/dbu_writer.sv
// rtl/dbu_writer.sv - debug write unit: button-driven hex entry and CPU debug-port write handshake
module dbu_writer #(
    parameter int TIMEOUT  = 255,
    parameter int MEM_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw,
    input  logic        shift,
    input  logic        commit,
    input  logic        clear,
    input  logic        inc,
    input  logic        dec,
    input  logic        m_rf,
    input  logic        wr_ack,
    output logic        wr_req,
    output logic        wr_sel,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] entry,
    output logic [3:0]  digits,
    output logic        busy,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    state_t        r_state, w_next;
    logic [4:0]    r_s1, r_s2, r_s3, r_pulse;
    logic [CW-1:0] r_cnt;
    logic          r_wr_req, r_wr_sel, r_mode;
    logic [31:0]   r_wr_addr, r_wr_data, r_entry;
    logic [3:0]    r_digits;

    logic [4:0]  w_raw;
    logic        w_idle, w_do_clear, w_do_commit, w_do_shift, w_do_inc, w_do_dec, w_mode_chg;
    logic [31:0] w_addr_up, w_addr_dn;

    // Pulse bit order: 0 clear, 1 commit, 2 shift, 3 inc, 4 dec.
    assign w_raw  = {dec, inc, shift, commit, clear};
    assign w_idle = (r_state == S_IDLE);

    // A commit pulse always consumes the cycle, even when it is ignored for lack of digits.
    assign w_do_clear  = r_pulse[0] && (w_idle || r_state == S_ERR);
    assign w_do_commit = w_idle && !r_pulse[0] && r_pulse[1] && (r_digits != 4'd0);
    assign w_do_shift  = w_idle && !r_pulse[0] && !r_pulse[1] && r_pulse[2];
    assign w_do_inc    = w_idle && !r_pulse[0] && !r_pulse[1] && !r_pulse[2] && r_pulse[3] && !r_pulse[4];
    assign w_do_dec    = w_idle && !r_pulse[0] && !r_pulse[1] && !r_pulse[2] && r_pulse[4] && !r_pulse[3];
    assign w_mode_chg  = w_idle && (m_rf != r_mode);

    assign w_addr_up = r_mode ? r_wr_addr + 32'(MEM_STEP) : {27'd0, r_wr_addr[4:0] + 5'd1};
    assign w_addr_dn = r_mode ? r_wr_addr - 32'(MEM_STEP) : {27'd0, r_wr_addr[4:0] - 5'd1};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_do_commit) w_next = S_REQ;
            S_REQ: begin
                if (wr_ack)
                    w_next = S_DONE;
                else if (r_cnt == CW'(TIMEOUT - 1))
                    w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   if (w_do_clear) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_pulse   <= '0;
            r_cnt     <= '0;
            r_wr_req  <= 1'b0;
            r_wr_sel  <= 1'b0;
            r_mode    <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_entry   <= '0;
            r_digits  <= '0;
        end else begin
            r_s1     <= w_raw;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_pulse  <= r_s2 & ~r_s3;
            r_state  <= w_next;
            r_wr_req <= (w_next == S_REQ);
            r_cnt    <= (r_state == S_REQ) ? r_cnt + CW'(1) : '0;

            if (w_mode_chg)
                r_mode <= m_rf;

            if (w_do_clear || r_state == S_DONE) begin
                r_entry  <= '0;
                r_digits <= '0;
            end else if (w_do_shift) begin
                r_entry  <= {r_entry[27:0], sw};
                r_digits <= (r_digits == 4'd8) ? 4'd8 : r_digits + 4'd1;
            end

            if (w_do_commit) begin
                r_wr_data <= r_entry;
                r_wr_sel  <= m_rf;
            end

            // Mode switch wins over button stepping; DONE only occurs outside IDLE.
            if (w_mode_chg)
                r_wr_addr <= '0;
            else if (r_state == S_DONE || w_do_inc)
                r_wr_addr <= w_addr_up;
            else if (w_do_dec)
                r_wr_addr <= w_addr_dn;
        end
    end

    assign wr_req  = r_wr_req;
    assign wr_sel  = r_wr_sel;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign entry   = r_entry;
    assign digits  = r_digits;
    assign busy    = (r_state == S_REQ) || (r_state == S_DONE);
    assign err     = (r_state == S_ERR);
endmodule

// File: tb/tb_dbu_writer.sv
// tb/tb_dbu_writer.sv - randomized self-checking bench for dbu_writer against a behavioural model
module tb_dbu_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw;
    logic        shift_b, commit_b, clear_b, inc_b, dec_b;
    logic        m_rf, wr_ack;
    logic        wr_req, wr_sel, busy, err;
    logic [31:0] wr_addr, wr_data, entry;
    logic [3:0]  digits;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_entry, m_addr;
    int          m_digits;

    localparam logic [4:0] B_CLEAR = 5'b00001, B_COMMIT = 5'b00010, B_SHIFT = 5'b00100,
                           B_INC = 5'b01000, B_DEC = 5'b10000;

    dbu_writer #(.TIMEOUT(255), .MEM_STEP(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .shift(shift_b), .commit(commit_b), .clear(clear_b),
        .inc(inc_b), .dec(dec_b), .m_rf(m_rf), .wr_ack(wr_ack), .wr_req(wr_req), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .entry(entry), .digits(digits), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Returns at the negedge right after the button action has taken effect.
    task automatic press(input logic [4:0] b);
        @(negedge clk);
        {dec_b, inc_b, shift_b, commit_b, clear_b} = b;
        @(negedge clk);
        {dec_b, inc_b, shift_b, commit_b, clear_b} = 5'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic model_shift(input logic [3:0] d);
        m_entry  = (m_entry << 4) | 32'(d);
        m_digits = (m_digits < 8) ? m_digits + 1 : 8;
    endtask

    task automatic model_step(input bit up);
        if (m_rf) m_addr = up ? m_addr + 32'd4 : m_addr - 32'd4;
        else      m_addr = up ? (m_addr + 32'd1) % 32 : (m_addr + 32'd31) % 32;
    endtask

    task automatic set_mode(input logic v);
        @(negedge clk);
        m_rf = v;
        @(negedge clk);
        m_addr = 32'd0;
        n_tests++;
        if (wr_addr !== 32'd0) begin n_fail++; $display("FAIL mode_switch_addr got=%h exp=00000000", wr_addr); end
    endtask

    task automatic do_clear();
        press(B_CLEAR);
        m_entry = 0; m_digits = 0;
        n_tests++;
        if (entry !== 32'd0 || digits !== 4'd0 || err !== 1'b0)
            begin n_fail++; $display("FAIL clear got entry=%h digits=%0d err=%0b exp 0/0/0", entry, digits, err); end
    endtask

    task automatic enter_digit(input logic [3:0] d);
        @(negedge clk);
        sw = d;
        press(B_SHIFT);
        model_shift(d);
    endtask

    task automatic do_write(input int delay);
        logic [31:0] e_data, e_addr;
        logic        e_sel;
        int          hi;
        e_data = m_entry; e_addr = m_addr; e_sel = m_rf;
        press(B_COMMIT);
        hi = 1;
        n_tests++;
        if (wr_req !== 1'b1 || busy !== 1'b1 || wr_data !== e_data || wr_sel !== e_sel || wr_addr !== e_addr) begin
            n_fail++;
            $display("FAIL write_issue got req=%0b busy=%0b data=%h sel=%0b addr=%h exp 1/1/%h/%0b/%h",
                     wr_req, busy, wr_data, wr_sel, wr_addr, e_data, e_sel, e_addr);
        end
        for (int i = 1; i < delay; i++) begin
            @(negedge clk);
            if (wr_req === 1'b1 && wr_data === e_data && wr_addr === e_addr) hi++;
        end
        n_tests++;
        if (hi !== delay) begin n_fail++; $display("FAIL write_hold got=%0d exp=%0d", hi, delay); end
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        n_tests++;
        if (wr_req !== 1'b0 || busy !== 1'b1)
            begin n_fail++; $display("FAIL write_done got req=%0b busy=%0b exp 0/1", wr_req, busy); end
        @(negedge clk);
        model_step(1'b1);
        m_entry = 0; m_digits = 0;
        n_tests++;
        if (busy !== 1'b0 || wr_addr !== m_addr || entry !== 32'd0 || digits !== 4'd0)
            begin n_fail++; $display("FAIL write_advance got busy=%0b addr=%h entry=%h digits=%0d exp 0/%h/0/0",
                                     busy, wr_addr, entry, digits, m_addr); end
    endtask

    task automatic test_reset();
        rst = 1'b1; sw = 4'd0; m_rf = 1'b0; wr_ack = 1'b0;
        {dec_b, inc_b, shift_b, commit_b, clear_b} = 5'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_entry = 0; m_addr = 0; m_digits = 0;
        n_tests++;
        if ({wr_req, wr_sel, busy, err, digits} !== 8'd0 || {wr_addr, wr_data, entry} !== 96'd0)
            begin n_fail++; $display("FAIL reset_state got req=%0b sel=%0b busy=%0b err=%0b addr=%h data=%h entry=%h digits=%0d exp all 0",
                                     wr_req, wr_sel, busy, err, wr_addr, wr_data, entry, digits); end
    endtask

    task automatic test_shift();
        do_clear();
        for (int i = 1; i <= 9; i++) enter_digit(4'(i));
        n_tests++;
        if (entry !== 32'h23456789 || digits !== 4'd8)
            begin n_fail++; $display("FAIL shift_nine got entry=%h digits=%0d exp 23456789/8", entry, digits); end
        for (int r = 0; r < 3; r++) begin
            int n;
            do_clear();
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) enter_digit(4'($urandom_range(0, 15)));
            n_tests++;
            if (entry !== m_entry || digits !== 4'(m_digits))
                begin n_fail++; $display("FAIL shift_random got entry=%h digits=%0d exp %h/%0d", entry, digits, m_entry, m_digits); end
        end
    endtask

    task automatic test_commit_empty();
        do_clear();
        press(B_COMMIT);
        wr_ack = 1'b1;
        repeat (3) @(negedge clk);
        wr_ack = 1'b0;
        n_tests++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || wr_addr !== m_addr)
            begin n_fail++; $display("FAIL commit_empty got req=%0b busy=%0b addr=%h exp 0/0/%h", wr_req, busy, wr_addr, m_addr); end
    endtask

    task automatic test_basic_write();
        set_mode(1'b1);
        do_clear();
        for (int i = 1; i <= 4; i++) enter_digit(4'(i));
        n_tests++;
        if (entry !== 32'h00001234) begin n_fail++; $display("FAIL basic_entry got=%h exp=00001234", entry); end
        do_write(3);
        n_tests++;
        if (wr_addr !== 32'd4 || wr_data !== 32'h00001234)
            begin n_fail++; $display("FAIL basic_result got addr=%h data=%h exp 00000004/00001234", wr_addr, wr_data); end
        for (int r = 0; r < 4; r++) begin
            if ($urandom_range(0, 1) == 1) set_mode(~m_rf);
            for (int i = 0, n = $urandom_range(1, 9); i < n; i++) enter_digit(4'($urandom_range(0, 15)));
            do_write($urandom_range(1, 20));
        end
    endtask

    task automatic test_addr_step();
        if (m_rf !== 1'b0) set_mode(1'b0);
        press(B_DEC); model_step(1'b0);
        n_tests++;
        if (wr_addr !== 32'd31) begin n_fail++; $display("FAIL rf_dec_wrap got=%h exp=0000001f", wr_addr); end
        press(B_INC); model_step(1'b1);
        n_tests++;
        if (wr_addr !== 32'd0) begin n_fail++; $display("FAIL rf_inc_wrap got=%h exp=00000000", wr_addr); end
        press(B_INC | B_DEC);
        n_tests++;
        if (wr_addr !== 32'd0) begin n_fail++; $display("FAIL inc_dec_same got=%h exp=00000000", wr_addr); end
        for (int mode = 0; mode < 2; mode++) begin
            set_mode(1'(mode));
            if (mode == 1) begin
                press(B_DEC); model_step(1'b0);
                n_tests++;
                if (wr_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL mem_dec_wrap got=%h exp=fffffffc", wr_addr); end
            end
            for (int i = 0; i < 8; i++) begin
                int op;
                op = $urandom_range(0, 2);
                press(op == 0 ? B_INC : op == 1 ? B_DEC : (B_INC | B_DEC));
                if (op < 2) model_step(op == 0);
                n_tests++;
                if (wr_addr !== m_addr) begin n_fail++; $display("FAIL addr_step_random got=%h exp=%h", wr_addr, m_addr); end
            end
        end
    endtask

    task automatic test_timeout();
        int hi;
        do_clear();
        enter_digit(4'($urandom_range(1, 15)));
        press(B_COMMIT);
        hi = 0;
        for (int i = 0; i < 400 && wr_req === 1'b1; i++) begin
            hi++;
            @(negedge clk);
        end
        n_tests++;
        if (hi !== 255) begin n_fail++; $display("FAIL timeout_len got=%0d exp=255", hi); end
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0 || wr_addr !== m_addr)
            begin n_fail++; $display("FAIL timeout_err got err=%0b busy=%0b addr=%h exp 1/0/%h", err, busy, wr_addr, m_addr); end
        sw = 4'hA;
        press(B_SHIFT);
        n_tests++;
        if (entry !== m_entry || err !== 1'b1)
            begin n_fail++; $display("FAIL err_shift_ignored got entry=%h err=%0b exp %h/1", entry, err, m_entry); end
        do_clear();
        n_tests++;
        if (busy !== 1'b0 || wr_req !== 1'b0) begin n_fail++; $display("FAIL err_clear_idle got busy=%0b req=%0b exp 0/0", busy, wr_req); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e_entry;
        do_clear();
        for (int i = 0; i < 3; i++) enter_digit(4'($urandom_range(0, 15)));
        e_entry = m_entry;
        sw = 4'hF;
        press(B_COMMIT | B_SHIFT);
        n_tests++;
        if (wr_req !== 1'b1 || wr_data !== e_entry || entry !== e_entry)
            begin n_fail++; $display("FAIL commit_shift got req=%0b data=%h entry=%h exp 1/%h/%h", wr_req, wr_data, entry, e_entry, e_entry); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_entry = 0; m_addr = 0; m_digits = 0;
        n_tests++;
        if ({wr_req, wr_sel, busy, err, digits} !== 8'd0 || {wr_addr, wr_data, entry} !== 96'd0)
            begin n_fail++; $display("FAIL rst_in_req got req=%0b busy=%0b addr=%h data=%h entry=%h exp all 0",
                                     wr_req, busy, wr_addr, wr_data, entry); end
        wr_ack = 1'b1;
        repeat (3) @(negedge clk);
        wr_ack = 1'b0;
        n_tests++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || wr_addr !== 32'd0)
            begin n_fail++; $display("FAIL late_ack got req=%0b busy=%0b addr=%h exp 0/0/0", wr_req, busy, wr_addr); end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_commit_empty();
        test_basic_write();
        test_addr_step();
        test_timeout();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
